// File: rtl/fft_result_arbiter.sv
// rtl/fft_result_arbiter.sv - round-robin arbiter that streams whole FFT result frames from three cores
// Optional 16-bit frame_id output is enabled by defining FFT_ARB_FRAME_ID_EN.
module fft_result_arbiter #(
  parameter int DATA_W = 32,
  parameter int BINS   = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [2:0]        in_valid,
  output logic [2:0]        in_ready,
  output logic [2:0]        grant,
  output logic [2:0]        ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        out_src
`ifdef FFT_ARB_FRAME_ID_EN
  ,
  output logic [15:0]       frame_id
`endif
);

  localparam int CNT_W = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BINS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, STREAM, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        gidx_q, gidx_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        ack_q, ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [1:0]        out_src_q, out_src_d;

  logic [1:0]        pick_idx;
  logic              pick_found;
  logic [2:0]        cand;
  logic [DATA_W-1:0] sel_data;
  logic              take;
  logic              xfer_in;
  logic              out_fire;
  logic              frame_done;

  // Round-robin search starting at the priority pointer, wrapping modulo 3.
  always_comb begin
    pick_idx   = ptr_q;
    pick_found = 1'b0;
    cand       = '0;
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, ptr_q} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!pick_found && req[cand[1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    case (gidx_q)
      2'd1:    sel_data = in_data_1;
      2'd2:    sel_data = in_data_2;
      default: sel_data = in_data_0;
    endcase
  end

  // Once the whole frame has been accepted, input stays closed even if out_last stalls.
  assign take       = (state_q == STREAM) && !full_q && (!out_valid_q || out_ready);
  assign xfer_in    = take && |(in_valid & grant_q);
  assign out_fire   = out_valid_q && out_ready;
  assign frame_done = (state_q == STREAM) && out_fire && out_last_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    ack_d       = 3'b000;
    cnt_d       = cnt_q;
    full_d      = full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (xfer_in) begin
      out_data_d  = sel_data;
      out_valid_d = 1'b1;
      out_last_d  = (cnt_q == LAST_IDX);
      out_src_d   = gidx_q;
      cnt_d       = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          grant_d = 3'(3'b001 << pick_idx);
          state_d = GRANT;
        end
      end
      GRANT: begin
        cnt_d   = '0;
        full_d  = 1'b0;
        state_d = STREAM;
      end
      STREAM: begin
        if (frame_done) begin
          ack_d   = grant_q;
          grant_d = 3'b000;
          ptr_d   = (gidx_q == 2'd2) ? 2'd0 : gidx_q + 2'd1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        full_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gidx_q      <= 2'd0;
      grant_q     <= 3'b000;
      ack_q       <= 3'b000;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_src_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

`ifdef FFT_ARB_FRAME_ID_EN
  logic [15:0] fid_q, fid_d;

  // Advances together with the ack pulse and wraps naturally at 16 bits.
  always_comb begin
    fid_d = fid_q;
    if (frame_done) fid_d = fid_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fid_q <= 16'd0;
    else       fid_q <= fid_d;
  end

  assign frame_id = fid_q;
`endif

  assign in_ready  = take ? grant_q : 3'b000;
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_fft_result_arbiter.sv
// tb/tb_fft_result_arbiter.sv - self-checking bench for fft_result_arbiter with a frame-level reference model
module tb_fft_result_arbiter;
  localparam int DATA_W = 32;
  localparam int BINS   = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        req;
  logic [DATA_W-1:0] in_data_0, in_data_1, in_data_2;
  logic [2:0]        in_valid;
  logic [2:0]        in_ready;
  logic [2:0]        grant;
  logic [2:0]        ack;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [1:0]        out_src;

  always #5 clk = ~clk;

  fft_result_arbiter #(.DATA_W(DATA_W), .BINS(BINS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in_data_0 (in_data_0),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .grant     (grant),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int p_model  = 0;
  logic [DATA_W-1:0] dmem [3][BINS];
  int idx [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [2:0] r);
    for (int i = 0; i < 3; i++)
      if (r[(p + i) % 3]) return (p + i) % 3;
    return -1;
  endfunction

  // Each core's words carry the core number in the top bits so stray data is recognisable.
  task automatic fill_all();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < BINS; j++) dmem[k][j] = {k[1:0], 30'($urandom)};
      idx[k] = 0;
    end
  endtask

  task automatic drive(input int g, input int vld_pct, input logic [2:0] noise, input int rdy_pct);
    logic [2:0] v;
    int j0, j1, j2;
    j0 = (idx[0] < BINS) ? idx[0] : BINS - 1;
    j1 = (idx[1] < BINS) ? idx[1] : BINS - 1;
    j2 = (idx[2] < BINS) ? idx[2] : BINS - 1;
    in_data_0 = dmem[0][j0];
    in_data_1 = dmem[1][j1];
    in_data_2 = dmem[2][j2];
    for (int k = 0; k < 3; k++)
      v[k] = (k == g) ? (int'($urandom_range(0, 99)) < vld_pct) : noise[k];
    in_valid  = v;
    out_ready = int'($urandom_range(0, 99)) < rdy_pct;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},     grant,     0);
    check({tag, "_ack"},       ack,       0);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_out_src"},   out_src,   0);
    check({tag, "_out_data"},  out_data,  0);
  endtask

  // Runs one frame from IDLE; called and returns on a falling edge (or just after one).
  task automatic run_frame(input logic [2:0] req_val, input int rdy_pct, input int vld_pct,
                           input logic [2:0] noise, input int drop_at, input int abort_at,
                           output int g);
    int beats, last_n;
    bit got_ack, contiguous, stall_prev;
    logic [DATA_W-1:0] data_prev;
    logic [2:0] exp_rdy;
    logic exp_ov;
    g = rr_pick(p_model, req_val);
    fill_all();
    contiguous = (rdy_pct >= 100) && (vld_pct >= 100);
    req        = req_val;
    beats      = 0;
    last_n     = -10;
    got_ack    = 1'b0;
    stall_prev = 1'b0;
    data_prev  = '0;
    for (int n = 0; n < BINS * 10 + 20 && !got_ack; n++) begin
      if (drop_at >= 0 && beats >= drop_at) req = 3'b000;
      drive(g, vld_pct, noise, rdy_pct);
      #1;
      exp_ov = (idx[g] > beats);
      check("out_valid", out_valid, exp_ov);
      exp_rdy = 3'b000;
      if (n >= 2 && idx[g] < BINS && (!exp_ov || out_ready)) exp_rdy[g] = 1'b1;
      check("in_ready", in_ready, exp_rdy);
      if (stall_prev) check("stall_hold", out_data, data_prev);
      if (ack != 3'b000) begin
        check("ack_core", ack, 64'(1 << g));
        check("ack_beats", beats, BINS);
        check("ack_grant_clear", grant, 0);
        check("ack_after_last", n, last_n + 1);
        if (contiguous) check("ack_latency", n, BINS + 3);
        got_ack = 1'b1;
      end else begin
        check("grant", grant, (n == 0) ? 64'd0 : 64'(1 << g));
      end
      if (out_valid && out_ready) begin
        beats++;
        if (beats <= BINS) begin
          check("out_data", out_data, dmem[g][beats-1]);
          check("out_src", out_src, g);
          check("out_last", out_last, beats == BINS);
          if (contiguous) check("no_bubble", n, beats + 2);
        end else begin
          check("extra_beat", beats, BINS);
        end
        if (beats == BINS) last_n = n;
      end
      if (in_valid[g] && in_ready[g]) idx[g]++;
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      if (abort_at >= 0 && beats == abort_at) begin
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        req      = 3'b000;
        in_valid = 3'b000;
        @(negedge clk);
        reset   = 1'b0;
        p_model = 0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          #1;
          check("abort_no_ack", ack, 0);
          check("abort_no_grant", grant, 0);
        end
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!got_ack) begin
      check("ack_timeout", 0, 1);
    end else begin
      #1;
      check("ack_one_cycle", ack, 0);
      check("idle_grant", grant, 0);
      p_model = (g + 1) % 3;
    end
  endtask

  task automatic idle(input int cycles);
    req      = 3'b000;
    in_valid = 3'b000;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int g;
    reset     = 1'b1;
    req       = 3'b000;
    in_valid  = 3'b000;
    out_ready = 1'b0;
    in_data_0 = '0;
    in_data_1 = '0;
    in_data_2 = '0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_frame(3'b001, 100, 100, 3'b000, -1, -1, g);
    check("single_core", g, 0);
    idle(3);

    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    p_model = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      run_frame(3'b111, 100, 100, 3'b000, -1, -1, g);
      check("rr_order", g, k % 3);
    end

    run_frame(3'b100, 100, 100, 3'b000, 50, -1, g);
    check("drop_req_core", g, 2);
    idle(2);

    run_frame(3'b010, 50, 70, 3'b000, -1, -1, g);
    check("backpressure_core", g, 1);
    idle(2);

    run_frame(3'b001, 60, 100, 3'b100, -1, -1, g);
    check("ignored_core", g, 0);
    idle(2);

    run_frame(3'b001, 70, 100, 3'b000, -1, 100, g);
    run_frame(3'b010, 100, 100, 3'b000, -1, -1, g);
    check("after_abort_core", g, 1);

    for (int k = 0; k < 3; k++) begin
      run_frame(3'($urandom_range(1, 7)), 75, 80, 3'($urandom), -1, -1, g);
      idle(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
